axi_lite_reg_slave: RTL and testbench
=====================================

// Module: axi_lite_reg_slave
// PURPOSE
//  AXI4-Lite responder (slave endpoint) holding NUM_REGS software-visible 32-bit registers.
//  Sits on an m*_axi master port of the bus interconnect and answers its write and read transactions.
//  Write and read channels run independent FSMs.
//  Register contents and per-register write strobes are exported to user logic.
// PARAMETERS
//  DATA_WIDTH  32    data bus width; multiple of 8
//  ADDR_WIDTH  8     byte address width
//  RESP_WIDTH  3     bresp/rresp width; OKAY=0, SLVERR=2
//  NUM_REGS    4     number of registers, word-spaced (4 bytes)
//  BASE_ADDR   0     byte address of register 0; must be 4-aligned
// PORTS
//  s0_axi_aclk     in   1                     single clock; all logic is posedge
//  s0_axi_areset   in   1                     synchronous, active-high reset
//  s0_axi_awaddr   in   ADDR_WIDTH            write address
//  s0_axi_awvalid  in   1                     write address valid
//  s0_axi_awready  out  1                     write address ready
//  s0_axi_wdata    in   DATA_WIDTH            write data
//  s0_axi_wstrb    in   DATA_WIDTH/8+1        byte strobes; bit [DATA_WIDTH/8] ignored (bus-compatible width)
//  s0_axi_wvalid   in   1                     write data valid
//  s0_axi_wready   out  1                     write data ready
//  s0_axi_bresp    out  RESP_WIDTH            write response
//  s0_axi_bvalid   out  1                     write response valid
//  s0_axi_bready   in   1                     write response ready
//  s0_axi_araddr   in   ADDR_WIDTH            read address
//  s0_axi_arvalid  in   1                     read address valid
//  s0_axi_arready  out  1                     read address ready
//  s0_axi_rdata    out  DATA_WIDTH            read data
//  s0_axi_rresp    out  RESP_WIDTH            read response
//  s0_axi_rvalid   out  1                     read data valid
//  s0_axi_rready   in   1                     read data ready
//  reg_q           out  NUM_REGS*DATA_WIDTH   register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//  reg_wr_pulse    out  NUM_REGS              1-cycle pulse on the cycle after reg i commits an OKAY write
// BEHAVIOUR
//  Reset (s0_axi_areset=1 at a clock edge):
//   - All outputs go to 0 and all registers to 0.
//   - Both FSMs return to IDLE; latched AW/W halves are discarded.
//   - An in-flight bvalid/rvalid drops without a handshake.
//  Address decode (both channels):
//   - Hit iff BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS and addr[1:0]==0.
//   - Index = (addr-BASE_ADDR)>>2.
//   - A miss answers SLVERR(2) and has no side effects.
//  Write FSM, states W_IDLE -> W_RESP:
//   - W_IDLE: awready=1 until AW is accepted, then 0; wready=1 until W is accepted, then 0.
//   - AW and W may arrive in either order or in the same cycle; each half is latched independently.
//   - On the edge where the second half is accepted, a hit updates byte b of reg[idx] iff wstrb[b]=1.
//   - On that same edge: bvalid=1 and bresp=OKAY/SLVERR take effect (visible next cycle); go to W_RESP.
//   - Latency: AW+W accepted together at edge N -> register value and bvalid visible in cycle N+1.
//   - W_RESP: awready=wready=0. bvalid and bresp are held stable until bvalid&bready.
//   - After the B handshake: go to W_IDLE with awready=wready=1 the next cycle.
//   - Throughput: at most one write per 2 cycles.
//  Read FSM, states R_IDLE -> R_DATA:
//   - R_IDLE: arready=1.
//   - On arvalid&arready at edge N: capture rdata=reg[idx] (0 on miss) and rresp.
//   - Also at edge N: rvalid=1 in cycle N+1, arready=0; go to R_DATA.
//   - R_DATA: rdata, rresp and rvalid are held stable until rvalid&rready, then return to R_IDLE.
//  Simultaneous events:
//   - A read accepted on the same edge a write commits to the same register returns the old value.
//   - The write and read FSMs never stall each other.
//   - reg_q reflects committed values only; no partial or speculative updates.
//   - SLVERR writes produce no reg_wr_pulse.
// TESTING
//  1. Write 0x0000_0004 data 0xDEADBEEF strb 0xF, AW+W same cycle -> reg_q[1]=0xDEADBEEF, bresp=0 in next cycle.
//  2. W at cycle 3 then AW at cycle 6 to 0x0, strb 0x3, data 0x1234_5678 -> reg0=0x0000_5678, bvalid from cycle 7.
//  3. Read 0x8 after writing 0xA5A5A5A5; rready low for 4 cycles -> rdata=0xA5A5A5A5 rresp=0, held until rready.
//  4. Write to 0x20 and read 0x6 -> bresp=2, rresp=2, rdata=0; no reg_wr_pulse; reg_q unchanged.
//  5. Read and write commit to reg2 on the same edge (old 0x11, new 0x22) -> rdata=0x11; next read returns 0x22.
//  6. Assert reset while bvalid=1 and rvalid=1 -> all outputs 0 next cycle; reg_q=0; awready=wready=arready=1 after release.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS 32-bit registers with
// independent write/read FSMs. Ports: s0_axi_* bus, reg_q, reg_wr_pulse.
module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REGS   = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                           s0_axi_aclk,
  input  logic                           s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
  input  logic                           s0_axi_awvalid,
  output logic                           s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
  input  logic [DATA_WIDTH/8:0]          s0_axi_wstrb,
  input  logic                           s0_axi_wvalid,
  output logic                           s0_axi_wready,
  output logic [RESP_WIDTH-1:0]          s0_axi_bresp,
  output logic                           s0_axi_bvalid,
  input  logic                           s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
  input  logic                           s0_axi_arvalid,
  output logic                           s0_axi_arready,
  output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s0_axi_rresp,
  output logic                           s0_axi_rvalid,
  input  logic                           s0_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [RESP_WIDTH-1:0] OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic logic dec_hit(
    input logic [ADDR_WIDTH-1:0] a
  );
    int ai;
    ai = int'(a);
    return (ai >= BASE_ADDR) &&
           (ai < BASE_ADDR + 4 * NUM_REGS) &&
           (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IW-1:0] dec_idx(
    input logic [ADDR_WIDTH-1:0] a
  );
    int ai;
    ai = int'(a) - BASE_ADDR;
    return IW'(ai >>> 2);
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [0:0]            w_state;
  logic                  aw_got;
  logic                  w_got;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  have_aw;
  logic                  have_w;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [NB-1:0]         ws;
  logic                  commit;
  logic                  w_hit;
  logic [IW-1:0]         w_idx;

  logic [0:0]            r_state;
  logic                  ar_hs;
  logic                  r_hit;
  logic [IW-1:0]         r_idx;

  logic                  unused_strb;
  assign unused_strb = s0_axi_wstrb[NB];

  assign aw_hs   = s0_axi_awvalid & s0_axi_awready;
  assign w_hs    = s0_axi_wvalid & s0_axi_wready;
  assign have_aw = aw_got | aw_hs;
  assign have_w  = w_got | w_hs;

  // A half latched on an earlier edge wins over the live bus value.
  assign wa = aw_got ? awaddr_q : s0_axi_awaddr;
  assign wd = w_got ? wdata_q : s0_axi_wdata;
  assign ws = w_got ? wstrb_q : s0_axi_wstrb[NB-1:0];

  assign commit = (w_state == W_IDLE) & have_aw & have_w;
  assign w_hit  = dec_hit(wa);
  assign w_idx  = dec_idx(wa);

  assign ar_hs = s0_axi_arvalid & s0_axi_arready;
  assign r_hit = dec_hit(s0_axi_araddr);
  assign r_idx = dec_idx(s0_axi_araddr);

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      w_state        <= W_IDLE;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      s0_axi_awready <= 1'b0;
      s0_axi_wready  <= 1'b0;
      s0_axi_bvalid  <= 1'b0;
      s0_axi_bresp   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (commit) begin
            w_state        <= W_RESP;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            s0_axi_awready <= 1'b0;
            s0_axi_wready  <= 1'b0;
            s0_axi_bvalid  <= 1'b1;
            s0_axi_bresp   <= w_hit ? OKAY : SLVERR;
          end else begin
            if (aw_hs) begin
              aw_got   <= 1'b1;
              awaddr_q <= s0_axi_awaddr;
            end
            if (w_hs) begin
              w_got   <= 1'b1;
              wdata_q <= s0_axi_wdata;
              wstrb_q <= s0_axi_wstrb[NB-1:0];
            end
            s0_axi_awready <= ~have_aw;
            s0_axi_wready  <= ~have_w;
          end
        end
        W_RESP: begin
          if (s0_axi_bready) begin
            w_state        <= W_IDLE;
            s0_axi_bvalid  <= 1'b0;
            s0_axi_awready <= 1'b1;
            s0_axi_wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && w_hit) begin
        for (int b = 0; b < NB; b++) begin
          if (ws[b]) begin
            regs[w_idx][8*b +: 8] <= wd[8*b +: 8];
          end
        end
        reg_wr_pulse[w_idx] <= 1'b1;
      end
    end
  end

  // Reads sample regs before any same-edge write lands: old value.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      r_state        <= R_IDLE;
      s0_axi_arready <= 1'b0;
      s0_axi_rvalid  <= 1'b0;
      s0_axi_rdata   <= '0;
      s0_axi_rresp   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state        <= R_DATA;
            s0_axi_arready <= 1'b0;
            s0_axi_rvalid  <= 1'b1;
            s0_axi_rdata   <= r_hit ? regs[r_idx] : '0;
            s0_axi_rresp   <= r_hit ? OKAY : SLVERR;
          end else begin
            s0_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s0_axi_rready) begin
            r_state        <= R_IDLE;
            s0_axi_rvalid  <= 1'b0;
            s0_axi_arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized self-checking bench for axi_lite_reg_slave
// against a register-array reference model.
module tb_axi_lite_reg_slave;

  localparam int NREG = 4;
  localparam int BASE = 0;

  logic         clk;
  logic         areset;
  logic [7:0]   awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [4:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [2:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [7:0]   araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [2:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_reg [NREG];

  axi_lite_reg_slave dut (
    .s0_axi_aclk    (clk),
    .s0_axi_areset  (areset),
    .s0_axi_awaddr  (awaddr),
    .s0_axi_awvalid (awvalid),
    .s0_axi_awready (awready),
    .s0_axi_wdata   (wdata),
    .s0_axi_wstrb   (wstrb),
    .s0_axi_wvalid  (wvalid),
    .s0_axi_wready  (wready),
    .s0_axi_bresp   (bresp),
    .s0_axi_bvalid  (bvalid),
    .s0_axi_bready  (bready),
    .s0_axi_araddr  (araddr),
    .s0_axi_arvalid (arvalid),
    .s0_axi_arready (arready),
    .s0_axi_rdata   (rdata),
    .s0_axi_rresp   (rresp),
    .s0_axi_rvalid  (rvalid),
    .s0_axi_rready  (rready),
    .reg_q          (reg_q),
    .reg_wr_pulse   (reg_wr_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_hit(input logic [7:0] a);
    int ai;
    ai = int'(a);
    return ai >= BASE && ai < BASE + 4 * NREG && ai % 4 == 0;
  endfunction

  function automatic int m_idx(input logic [7:0] a);
    return (int'(a) - BASE) / 4;
  endfunction

  function automatic logic [127:0] mq();
    return {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  function automatic logic [46:0] outs();
    return {awready, wready, bvalid, bresp, arready,
            rvalid, rdata, rresp, reg_wr_pulse};
  endfunction

  task automatic m_write(
    input logic [7:0]  a,
    input logic [31:0] d,
    input logic [4:0]  s
  );
    int i;
    if (m_hit(a)) begin
      i = m_idx(a);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) m_reg[i][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic do_write(
    input logic [7:0]  a,
    input logic [31:0] d,
    input logic [4:0]  s,
    input int          aw_d,
    input int          w_d,
    input int          b_d
  );
    int cyc;
    bit aw_done;
    bit w_done;
    bit afire;
    bit wfire;
    logic [2:0] er;
    logic [3:0] ep;
    cyc = 0;
    aw_done = 0;
    w_done = 0;
    er = m_hit(a) ? 3'd0 : 3'd2;
    ep = m_hit(a) ? 4'(1 << m_idx(a)) : 4'd0;
    while (!(aw_done && w_done) && cyc < 50) begin
      check("wr_no_early_b", bvalid, 0);
      awvalid = !aw_done && cyc >= aw_d;
      awaddr  = a;
      wvalid  = !w_done && cyc >= w_d;
      wdata   = d;
      wstrb   = s;
      afire   = awvalid && awready;
      wfire   = wvalid && wready;
      tick();
      cyc++;
      if (afire) aw_done = 1;
      if (wfire) w_done = 1;
    end
    awvalid = 0;
    wvalid  = 0;
    check("wr_hs_done", {aw_done, w_done}, 2'b11);
    m_write(a, d, s);
    check("wr_bvalid", bvalid, 1);
    check("wr_bresp", bresp, er);
    check("wr_reg_q", reg_q, mq());
    check("wr_pulse", reg_wr_pulse, ep);
    check("wr_rdy_low", {awready, wready}, 2'b00);
    for (int k = 0; k < b_d; k++) begin
      tick();
      check("wr_b_hold", {bvalid, bresp}, {1'b1, er});
      check("wr_pulse_once", reg_wr_pulse, 0);
    end
    bready = 1;
    tick();
    bready = 0;
    check("wr_b_drop", bvalid, 0);
    check("wr_rdy_back", {awready, wready}, 2'b11);
    check("wr_reg_q_after", reg_q, mq());
  endtask

  task automatic do_read(
    input logic [7:0] a,
    input int         ar_d,
    input int         r_d
  );
    int cyc;
    bit done;
    bit fire;
    logic [31:0] ed;
    logic [2:0]  er;
    ed = m_hit(a) ? m_reg[m_idx(a)] : 32'd0;
    er = m_hit(a) ? 3'd0 : 3'd2;
    cyc = 0;
    done = 0;
    while (!done && cyc < 50) begin
      arvalid = cyc >= ar_d;
      araddr  = a;
      fire    = arvalid && arready;
      tick();
      cyc++;
      if (fire) done = 1;
    end
    arvalid = 0;
    check("rd_ar_done", done, 1);
    check("rd_rvalid", rvalid, 1);
    check("rd_rdata", rdata, ed);
    check("rd_rresp", rresp, er);
    check("rd_arready_low", arready, 0);
    for (int k = 0; k < r_d; k++) begin
      tick();
      check("rd_hold", {rvalid, rdata, rresp}, {1'b1, ed, er});
    end
    rready = 1;
    tick();
    rready = 0;
    check("rd_r_drop", rvalid, 0);
    check("rd_arready_back", arready, 1);
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic [127:0] q0;
    areset  = 1;
    awaddr  = 0;
    awvalid = 0;
    wdata   = 0;
    wstrb   = 0;
    wvalid  = 0;
    bready  = 0;
    araddr  = 0;
    arvalid = 0;
    rready  = 0;
    for (int i = 0; i < NREG; i++) m_reg[i] = 0;

    tick();
    tick();
    check("rst_outs", outs(), 0);
    check("rst_reg_q", reg_q, 0);
    areset = 0;
    tick();
    check("rst_rdy", {awready, wready, arready}, 3'b111);

    do_write(8'h04, 32'hDEAD_BEEF, 5'h0F, 0, 0, 0);
    do_write(8'h00, 32'h1234_5678, 5'h03, 6, 3, 1);
    check("t2_reg0", reg_q[31:0], 32'h0000_5678);

    do_write(8'h08, 32'hA5A5_A5A5, 5'h0F, 0, 0, 2);
    do_read(8'h08, 0, 4);

    q0 = mq();
    do_write(8'h20, 32'hFFFF_FFFF, 5'h1F, 0, 1, 0);
    check("t4_q_unch", reg_q, q0);
    do_read(8'h06, 0, 1);

    do_write(8'h08, 32'h0000_0011, 5'h0F, 0, 0, 0);
    check("t5_rdy", {awready, wready, arready}, 3'b111);
    awaddr  = 8'h08;
    wdata   = 32'h0000_0022;
    wstrb   = 5'h0F;
    araddr  = 8'h08;
    awvalid = 1;
    wvalid  = 1;
    arvalid = 1;
    tick();
    awvalid = 0;
    wvalid  = 0;
    arvalid = 0;
    m_write(8'h08, 32'h0000_0022, 5'h0F);
    check("t5_rdata_old", {rvalid, rdata}, {1'b1, 32'h11});
    check("t5_bvalid", {bvalid, bresp}, 4'b1000);
    check("t5_reg_q", reg_q, mq());
    bready = 1;
    rready = 1;
    tick();
    bready = 0;
    rready = 0;
    check("t5_drop", {bvalid, rvalid}, 2'b00);
    do_read(8'h08, 1, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 63));
      else a = 8'(4 * $urandom_range(0, NREG - 1));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      end else begin
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    awaddr  = 8'h0C;
    wdata   = 32'h5555_AAAA;
    wstrb   = 5'h0F;
    araddr  = 8'h0C;
    awvalid = 1;
    wvalid  = 1;
    arvalid = 1;
    tick();
    awvalid = 0;
    wvalid  = 0;
    arvalid = 0;
    check("t6_both_valid", {bvalid, rvalid}, 2'b11);
    areset = 1;
    tick();
    for (int i = 0; i < NREG; i++) m_reg[i] = 0;
    check("t6_outs", outs(), 0);
    check("t6_reg_q", reg_q, mq());
    areset = 0;
    tick();
    check("t6_rdy", {awready, wready, arready}, 3'b111);
    check("t6_valid_low", {bvalid, rvalid}, 2'b00);
    do_read(8'h0C, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
